// File: rtl/predecode_queue.sv
// Instruction pre-decode FIFO: decodes fetched instructions on enqueue and buffers the decoded records.
// Optional feature: define PREDECODE_ILLEGAL_EN to add the out_illegal flag.
module predecode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int SHW   = $clog2(XLEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [6:0]               out_opcode,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_adr1,
  output logic [4:0]               out_adr2,
  output logic [2:0]               out_funct3,
  output logic [6:0]               out_funct7,
  output logic [XLEN-1:0]          out_imm,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
`ifdef PREDECODE_ILLEGAL_EN
  ,
  output logic                     out_illegal
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);
  localparam logic [PW-1:0] ONE_PTR = PW'(1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
`ifdef PREDECODE_ILLEGAL_EN
    logic            ill;
`endif
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      adr1;
    logic [4:0]      adr2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          dec;
  entry_t          head;
  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            push, pop;
  logic [6:0]      op;

  assign op = in_instr[6:0];

  always_comb begin
    dec        = '0;
    dec.opcode = op;
    dec.pc     = in_pc;
    unique case (op)
      OP_LUI, OP_AUIPC: begin
        dec.rd  = in_instr[11:7];
        dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        dec.rd  = in_instr[11:7];
        dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      OP_JALR, OP_LOAD: begin
        dec.rd     = in_instr[11:7];
        dec.funct3 = in_instr[14:12];
        dec.adr1   = in_instr[19:15];
        dec.imm    = XLEN'($signed(in_instr[31:20]));
      end
      OP_BRANCH: begin
        dec.funct3 = in_instr[14:12];
        dec.adr1   = in_instr[19:15];
        dec.adr2   = in_instr[24:20];
        dec.imm    = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                    in_instr[11:8], 1'b0}));
      end
      OP_STORE: begin
        dec.funct3 = in_instr[14:12];
        dec.adr1   = in_instr[19:15];
        dec.adr2   = in_instr[24:20];
        dec.imm    = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      OP_IMM: begin
        dec.rd     = in_instr[11:7];
        dec.funct3 = in_instr[14:12];
        dec.adr1   = in_instr[19:15];
        // shifts: on RV64 funct7[0] doubles as shamt[5]
        if (in_instr[13:12] == 2'b01) begin
          dec.funct7 = in_instr[31:25];
          dec.imm    = XLEN'(in_instr[20 +: SHW]);
        end else begin
          dec.imm    = XLEN'($signed(in_instr[31:20]));
        end
      end
      default: begin
        dec.rd     = in_instr[11:7];
        dec.funct3 = in_instr[14:12];
        dec.adr1   = in_instr[19:15];
        dec.adr2   = in_instr[24:20];
        dec.funct7 = in_instr[31:25];
      end
    endcase
`ifdef PREDECODE_ILLEGAL_EN
    dec.ill = (in_instr[1:0] != 2'b11) ||
              !(op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                           OP_LOAD, OP_STORE, OP_IMM, OP_OP});
`endif
  end

  assign out_valid = (count_q != '0);
  assign in_ready  = !rst && !flush && ((count_q != FULL_CNT) || out_ready);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ONE_PTR;
    if (pop)  rd_ptr_d = rd_ptr_q + ONE_PTR;
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: the head is masked whenever the queue is empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  assign head       = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_opcode = head.opcode;
  assign out_rd     = head.rd;
  assign out_adr1   = head.adr1;
  assign out_adr2   = head.adr2;
  assign out_funct3 = head.funct3;
  assign out_funct7 = head.funct7;
  assign out_imm    = head.imm;
  assign out_pc     = head.pc;
  assign count      = count_q;
`ifdef PREDECODE_ILLEGAL_EN
  assign out_illegal = head.ill;
`endif

endmodule

// File: tb/tb_predecode_queue.sv
// Scoreboard bench for predecode_queue (XLEN=32, DEPTH=4); covers PREDECODE_ILLEGAL_EN when defined.
module tb_predecode_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd, out_adr1, out_adr2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm, out_pc;
  logic [2:0]  count;
  logic        ill_obs;
`ifdef PREDECODE_ILLEGAL_EN
  logic        out_illegal;
  localparam logic ILL = 1'b1;
  assign ill_obs = out_illegal;
`else
  localparam logic ILL = 1'b0;
  assign ill_obs = 1'b0;
`endif

  predecode_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_adr1(out_adr1), .out_adr2(out_adr2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm), .out_pc(out_pc),
    .count(count)
`ifdef PREDECODE_ILLEGAL_EN
    , .out_illegal(out_illegal)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]  t_instr [15];
  logic [127:0] t_exp   [15];
  logic [127:0] sb [$];
  logic [31:0]  pc_ctr = 32'h1000;
  logic         hold_pend = 1'b0;
  logic [127:0] hold_obs = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic ill, input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] a1, input logic [4:0] a2, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [31:0] imm);
    return {31'b0, ill, op, rd, a1, a2, f3, f7, imm, 32'h0};
  endfunction

  // one clock cycle: drive, check pre-edge state, update scoreboard at the edge
  task automatic cyc(input logic r, input logic fl, input logic v, input int idx, input logic ordy);
    logic [127:0] obs, e;
    logic acc, pop;
    rst = r; flush = fl; in_valid = v; out_ready = ordy;
    in_instr = v ? t_instr[idx] : 32'h0;
    in_pc = pc_ctr;
    #1;
    obs = {31'b0, ill_obs, out_opcode, out_rd, out_adr1, out_adr2, out_funct3, out_funct7,
           out_imm, out_pc};
    chk("in_ready", 128'(in_ready), 128'(!r && !fl && (sb.size() < 4 || ordy)));
    chk("count", 128'(count), 128'(sb.size()));
    chk("out_valid", 128'(out_valid), 128'(sb.size() != 0));
    if (!out_valid) chk("idle_zero", obs, 128'h0);
    if (hold_pend) chk("hold", obs, hold_obs);
    acc = v && in_ready;
    pop = out_valid && ordy && !fl && !r;
    hold_pend = out_valid && !ordy && !fl && !r;
    hold_obs = obs;
    @(posedge clk);
    if (r || fl) begin
      sb.delete();
    end else begin
      if (pop && sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop", obs, e);
      end
      if (acc) sb.push_back(t_exp[idx] | {96'h0, pc_ctr});
    end
    if (acc) pc_ctr = pc_ctr + 32'd4;
    @(negedge clk);
  endtask

  initial begin
    t_instr[0]  = 32'hFFF10093; t_exp[0]  = mk(0,   7'h13, 1,  2,  0,  0, 7'h00, 32'hFFFFFFFF);
    t_instr[1]  = 32'h40525193; t_exp[1]  = mk(0,   7'h13, 3,  4,  0,  5, 7'h20, 32'h00000005);
    t_instr[2]  = 32'hFFDFF0EF; t_exp[2]  = mk(0,   7'h6F, 1,  0,  0,  0, 7'h00, 32'hFFFFFFFC);
    t_instr[3]  = 32'h123452B7; t_exp[3]  = mk(0,   7'h37, 5,  0,  0,  0, 7'h00, 32'h12345000);
    t_instr[4]  = 32'h002081B3; t_exp[4]  = mk(0,   7'h33, 3,  1,  2,  0, 7'h00, 32'h0);
    t_instr[5]  = 32'h402081B3; t_exp[5]  = mk(0,   7'h33, 3,  1,  2,  0, 7'h20, 32'h0);
    t_instr[6]  = 32'h0020A423; t_exp[6]  = mk(0,   7'h23, 0,  1,  2,  2, 7'h00, 32'h00000008);
    t_instr[7]  = 32'hFE208CE3; t_exp[7]  = mk(0,   7'h63, 0,  1,  2,  0, 7'h00, 32'hFFFFFFF8);
    t_instr[8]  = 32'hFFC32283; t_exp[8]  = mk(0,   7'h03, 5,  6,  0,  2, 7'h00, 32'hFFFFFFFC);
    t_instr[9]  = 32'h80000397; t_exp[9]  = mk(0,   7'h17, 7,  0,  0,  0, 7'h00, 32'h80000000);
    t_instr[10] = 32'h01F09093; t_exp[10] = mk(0,   7'h13, 1,  1,  0,  1, 7'h00, 32'h0000001F);
    t_instr[11] = 32'h00008067; t_exp[11] = mk(0,   7'h67, 0,  1,  0,  0, 7'h00, 32'h0);
    t_instr[12] = 32'hFFFFFFFF; t_exp[12] = mk(ILL, 7'h7F, 31, 31, 31, 7, 7'h7F, 32'h0);
    t_instr[13] = 32'h0000007F; t_exp[13] = mk(ILL, 7'h7F, 0,  0,  0,  0, 7'h00, 32'h0);
    t_instr[14] = 32'h00000013; t_exp[14] = mk(0,   7'h13, 0,  0,  0,  0, 7'h00, 32'h0);

    @(posedge clk);
    @(negedge clk);
    cyc(1, 0, 0, 0, 0);

    // single pushes and streaming
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 2, 1);
    cyc(0, 0, 1, 3, 1);
    cyc(0, 0, 0, 0, 1);

    // fill to full, rejected push, then push+pop while full
    for (int i = 4; i < 8; i++) cyc(0, 0, 1, i, 0);
    cyc(0, 0, 1, 9, 0);
    for (int i = 8; i < 12; i++) cyc(0, 0, 1, i, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);

    // flush with three stored and a pending input
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, i, 0);
    cyc(0, 1, 1, 3, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 4, 1);
    cyc(0, 0, 0, 0, 1);

    // reset mid-stream
    cyc(0, 0, 1, 5, 0);
    cyc(0, 0, 1, 6, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 1, 7, 1);
    cyc(0, 0, 0, 0, 1);

    // unknown opcodes
    cyc(0, 0, 1, 12, 1);
    cyc(0, 0, 1, 13, 1);
    cyc(0, 0, 1, 14, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    chk("sb_empty", 128'(sb.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
